prim_arb_mux_nx1: RTL and testbench
===================================

Name: prim_arb_mux_nx1

Overview:
Parametrised N:1 arbitrated multiplexer with valid/ready handshake on every input channel and on the output. It is the successor to the fixed 8x1 combinational primitive mux. Adds per-channel request arbitration (fixed-priority or round-robin), a registered output stage, and back-pressure. Used wherever several producers share one datapath, e.g. writeback, LSU request and debug paths.

Parameters:
- WIDTH, 32, data width per channel.
- N_CH, 8, number of input channels; must be at least 2.
- ARB_MODE, 1, arbitration mode: 0 = fixed priority (lowest index wins), 1 = round-robin.
- SEL_W, $clog2(N_CH), width of the channel-id output. Derived; do not override.

Ports:
- i_clk  in  1  clock.
- i_rst_n  in  1  reset; synchronous, active-low.
- i_valid  in  N_CH  per-channel request valid.
- i_data  in  N_CH*WIDTH  packed channel data; channel k occupies bits [k*WIDTH +: WIDTH].
- o_ready  out  N_CH  per-channel accept, one-hot or zero.
- o_valid  out  1  output register holds valid data.
- o_data  out  WIDTH  registered selected data.
- o_sel  out  SEL_W  index of the channel that supplied o_data.
- i_ready  in  1  downstream accept.

Behaviour:
- Reset (i_rst_n=0 at a rising edge):
  - o_valid=0, o_data=0, o_sel=0.
  - Round-robin pointer = 0; lock state cleared.
  - o_ready is forced to 0 while i_rst_n=0.
- Load condition: load = ~o_valid | i_ready. It is computed combinationally, so there is no bubble under continuous traffic.
- Grant:
  - Computed combinationally from i_valid and the pointer, but only when load=1; otherwise o_ready=0.
  - o_ready[k]=1 only for the granted channel k, and only when i_valid[k]=1.
  - A channel transfer occurs when i_valid[k] & o_ready[k].
- Fixed priority (ARB_MODE=0): the lowest-index asserted i_valid wins. The pointer is unused.
- Round-robin (ARB_MODE=1):
  - Search starts at the pointer and proceeds upward, wrapping from N_CH-1 to 0.
  - After a transfer from channel k, pointer = k+1, wrapping to 0 when k = N_CH-1.
  - With no transfer, the pointer holds.
- Output register, evaluated at each edge:
  - On a transfer from k: o_data <= data of k, o_sel <= k, o_valid <= 1. Latency is exactly 1 cycle from input transfer to o_valid.
  - Else if i_ready=1: o_valid <= 0. o_data and o_sel hold their last values.
  - Else: hold everything.
- Simultaneous events:
  - If o_valid=1 and i_ready=1 in the same cycle as a new transfer, the output is replaced with the new data and o_valid stays 1. Full throughput is 1 beat/cycle.
- Boundary conditions:
  - No i_valid asserted: o_ready=0 and no pointer change.
  - A single requester gets back-to-back grants every cycle, regardless of the pointer.
  - i_ready=0 with o_valid=1: every o_ready is 0 and o_data is stable.
  - A reset asserted mid-transfer discards the in-flight output beat.
- Upstream rule: i_data is sampled only on a transfer; once i_valid is raised it must hold until accepted.

Optional Feature:
- Macro: PRIM_ARB_MUX_LOCK_EN.
- Defined:
  - Adds input i_last (N_CH bits, per-channel end-of-packet).
  - Once channel k transfers a beat with i_last[k]=0, arbitration locks to k. Only k may be granted until a beat with i_last[k]=1 transfers, then the lock releases.
  - The round-robin pointer advances only on the beat that releases the lock.
  - Adds output o_last (1 bit), registered alongside o_data; reset value 0.
- Undefined: no i_last/o_last ports, and every beat is arbitrated independently.

Decomposition:
- Shared package prim_pkg:
  - typedef arb_mode_e {ARB_FIXED=0, ARB_RR=1}.
  - Function for the one-hot-to-index conversion.
- Sub-module prim_arb_rr: an N_CH-wide request-to-one-hot grant arbiter. Holds the pointer and takes the mode parameter, an advance strobe, and the lock input.
- prim_arb_mux_nx1 instantiates prim_arb_rr and contains the output register.

Test Plan:
1. Reset: hold i_rst_n=0 for 2 cycles with all i_valid=1. Expect o_valid=0, o_ready=0, o_data=0. After release, a grant to channel 0 on the first cycle.
2. Round-robin, N_CH=8: all i_valid=1, i_ready=1, i_data[k]=k+0x100. Expect o_sel sequence 0,1,...,7,0 on consecutive cycles, o_data matching, o_valid continuously 1.
3. Fixed priority: i_valid=8'b1010_0100. Expect channel 2 granted repeatedly and channels 5 and 7 starved until i_valid[2] drops.
4. Back-pressure: i_ready=0 for 3 cycles while o_valid=1. Expect o_ready=0 and o_data stable. When i_ready rises, expect the next grant on the same cycle with no bubble.
5. Wrap and sparse requests: pointer at 6 with only channels 1 and 6 requesting. Expect grant order 6, 1, 6.
6. Lock (PRIM_ARB_MUX_LOCK_EN): channel 3 sends 4 beats with last only on the 4th while channel 0 also requests. Expect o_sel=3 for 4 beats, then o_sel=0.

Source files
------------

// File: rtl/prim_pkg.sv
// Shared types and helpers for the prim_* arbitration primitives.
package prim_pkg;

    typedef enum logic {
        ARB_FIXED = 1'b0,
        ARB_RR    = 1'b1
    } arb_mode_e;

    // Upper bound on channel count accepted by onehot2idx.
    localparam int MAX_CH    = 64;
    localparam int MAX_SEL_W = 6;

    // OR-reduces the indices of set bits; exact for one-hot or zero inputs.
    function automatic logic [MAX_SEL_W-1:0] onehot2idx(input logic [MAX_CH-1:0] oh);
        logic [MAX_SEL_W-1:0] idx;
        idx = '0;
        for (int i = 0; i < MAX_CH; i++) begin
            if (oh[i]) begin
                idx = idx | MAX_SEL_W'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/prim_arb_rr.sv
// Request-to-one-hot grant arbiter: fixed priority or round-robin, with an
// optional lock mask that restricts arbitration to a single channel.
module prim_arb_rr
    import prim_pkg::*;
#(
    parameter int N_CH     = 8,
    parameter int ARB_MODE = 1,
    parameter int SEL_W    = $clog2(N_CH)
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic [N_CH-1:0] req_i,
    input  logic            advance_i,
    input  logic            lock_i,
    input  logic [N_CH-1:0] lock_oh_i,
    output logic [N_CH-1:0] gnt_o
);

    localparam bit IsRr = (ARB_MODE == int'(ARB_RR));

    logic [SEL_W-1:0] ptr_q;
    logic [SEL_W-1:0] ptr_d;
    logic [SEL_W-1:0] start;
    logic [SEL_W-1:0] gnt_idx;
    logic [SEL_W:0]   pos;
    logic [N_CH-1:0]  req_m;
    logic             found;

    assign req_m = lock_i ? (req_i & lock_oh_i) : req_i;
    assign start = IsRr ? ptr_q : '0;

    // Scan upward from start, wrapping at N_CH; first requester wins.
    always_comb begin
        gnt_o = '0;
        found = 1'b0;
        pos   = '0;
        for (int i = 0; i < N_CH; i++) begin
            pos = {1'b0, start} + (SEL_W+1)'(i);
            if (pos >= (SEL_W+1)'(N_CH)) begin
                pos = pos - (SEL_W+1)'(N_CH);
            end
            if (!found && req_m[pos[SEL_W-1:0]]) begin
                gnt_o[pos[SEL_W-1:0]] = 1'b1;
                found = 1'b1;
            end
        end
    end

    assign gnt_idx = SEL_W'(onehot2idx(MAX_CH'(gnt_o)));

    always_comb begin
        if (gnt_idx == SEL_W'(N_CH - 1)) begin
            ptr_d = '0;
        end else begin
            ptr_d = gnt_idx + SEL_W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            ptr_q <= '0;
        end else if (IsRr && advance_i) begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/prim_arb_mux_nx1.sv
// N:1 arbitrated mux with valid/ready on every channel and a registered output.
// Define PRIM_ARB_MUX_LOCK_EN to add i_last/o_last and packet-level locking.
module prim_arb_mux_nx1
    import prim_pkg::*;
#(
    parameter int WIDTH    = 32,
    parameter int N_CH     = 8,
    parameter int ARB_MODE = 1,
    parameter int SEL_W    = $clog2(N_CH)
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic [N_CH-1:0]       i_valid,
    input  logic [N_CH*WIDTH-1:0] i_data,
`ifdef PRIM_ARB_MUX_LOCK_EN
    input  logic [N_CH-1:0]       i_last,
`endif
    output logic [N_CH-1:0]       o_ready,
    output logic                  o_valid,
    output logic [WIDTH-1:0]      o_data,
    output logic [SEL_W-1:0]      o_sel,
`ifdef PRIM_ARB_MUX_LOCK_EN
    output logic                  o_last,
`endif
    input  logic                  i_ready
);

    logic             load;
    logic             xfer;
    logic             advance;
    logic             lock;
    logic [N_CH-1:0]  lock_oh;
    logic [N_CH-1:0]  gnt;
    logic [SEL_W-1:0] xfer_idx;
    logic [WIDTH-1:0] ch_data [N_CH];

    logic             o_valid_q, o_valid_d;
    logic [WIDTH-1:0] o_data_q,  o_data_d;
    logic [SEL_W-1:0] o_sel_q,   o_sel_d;

    for (genvar g = 0; g < N_CH; g++) begin : g_unpack
        assign ch_data[g] = i_data[g*WIDTH +: WIDTH];
    end

    prim_arb_rr #(
        .N_CH     (N_CH),
        .ARB_MODE (ARB_MODE),
        .SEL_W    (SEL_W)
    ) u_arb (
        .clk_i     (i_clk),
        .rst_ni    (i_rst_n),
        .req_i     (i_valid),
        .advance_i (advance),
        .lock_i    (lock),
        .lock_oh_i (lock_oh),
        .gnt_o     (gnt)
    );

    // Accept a new beat whenever the output slot is empty or draining this cycle.
    assign load     = ~o_valid_q | i_ready;
    assign o_ready  = (i_rst_n && load) ? (gnt & i_valid) : '0;
    assign xfer     = |o_ready;
    assign xfer_idx = SEL_W'(onehot2idx(MAX_CH'(o_ready)));

`ifdef PRIM_ARB_MUX_LOCK_EN
    logic            lock_q, lock_d;
    logic [N_CH-1:0] lock_oh_q, lock_oh_d;
    logic            o_last_q, o_last_d;
    logic            last_beat;

    assign last_beat = |(o_ready & i_last);

    always_comb begin
        lock_d    = lock_q;
        lock_oh_d = lock_oh_q;
        o_last_d  = o_last_q;
        if (xfer) begin
            lock_d    = ~last_beat;
            lock_oh_d = o_ready;
            o_last_d  = last_beat;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            lock_q    <= 1'b0;
            lock_oh_q <= '0;
            o_last_q  <= 1'b0;
        end else begin
            lock_q    <= lock_d;
            lock_oh_q <= lock_oh_d;
            o_last_q  <= o_last_d;
        end
    end

    // Pointer moves only when a packet completes, so fairness is per packet.
    assign lock    = lock_q;
    assign lock_oh = lock_oh_q;
    assign advance = xfer & last_beat;
    assign o_last  = o_last_q;
`else
    assign lock    = 1'b0;
    assign lock_oh = '0;
    assign advance = xfer;
`endif

    always_comb begin
        o_valid_d = o_valid_q;
        o_data_d  = o_data_q;
        o_sel_d   = o_sel_q;
        if (xfer) begin
            o_valid_d = 1'b1;
            o_data_d  = ch_data[xfer_idx];
            o_sel_d   = xfer_idx;
        end else if (i_ready) begin
            o_valid_d = 1'b0;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            o_valid_q <= 1'b0;
            o_data_q  <= '0;
            o_sel_q   <= '0;
        end else begin
            o_valid_q <= o_valid_d;
            o_data_q  <= o_data_d;
            o_sel_q   <= o_sel_d;
        end
    end

    assign o_valid = o_valid_q;
    assign o_data  = o_data_q;
    assign o_sel   = o_sel_q;

endmodule

// File: tb/tb_prim_arb_mux_nx1.sv
// Table-driven bench for prim_arb_mux_nx1 with a one-deep output scoreboard;
// round-robin and fixed-priority instances share stimulus.
module tb_prim_arb_mux_nx1;

    localparam int W  = 32;
    localparam int N  = 8;
    localparam int SW = 3;

    logic           i_clk = 1'b0;
    logic           rst_n;
    logic [N-1:0]   valid;
    logic [N*W-1:0] data;
    logic           rdy;
`ifdef PRIM_ARB_MUX_LOCK_EN
    logic [N-1:0]   last;
    logic           last_rr, last_fp;
`endif

    logic [N-1:0]   ready_rr, ready_fp;
    logic           valid_rr, valid_fp;
    logic [W-1:0]   data_rr,  data_fp;
    logic [SW-1:0]  sel_rr,   sel_fp;

    bit             use_rr;
    logic [N-1:0]   cur_ready;
    logic           cur_valid;
    logic [W-1:0]   cur_data;
    logic [SW-1:0]  cur_sel;
`ifdef PRIM_ARB_MUX_LOCK_EN
    logic           cur_last;
    assign cur_last = use_rr ? last_rr : last_fp;
`endif
    assign cur_ready = use_rr ? ready_rr : ready_fp;
    assign cur_valid = use_rr ? valid_rr : valid_fp;
    assign cur_data  = use_rr ? data_rr  : data_fp;
    assign cur_sel   = use_rr ? sel_rr   : sel_fp;

    always #5 i_clk = ~i_clk;

    prim_arb_mux_nx1 #(.WIDTH(W), .N_CH(N), .ARB_MODE(1)) u_rr (
        .i_clk   (i_clk),
        .i_rst_n (rst_n),
        .i_valid (valid),
        .i_data  (data),
`ifdef PRIM_ARB_MUX_LOCK_EN
        .i_last  (last),
`endif
        .o_ready (ready_rr),
        .o_valid (valid_rr),
        .o_data  (data_rr),
        .o_sel   (sel_rr),
`ifdef PRIM_ARB_MUX_LOCK_EN
        .o_last  (last_rr),
`endif
        .i_ready (rdy)
    );

    prim_arb_mux_nx1 #(.WIDTH(W), .N_CH(N), .ARB_MODE(0)) u_fp (
        .i_clk   (i_clk),
        .i_rst_n (rst_n),
        .i_valid (valid),
        .i_data  (data),
`ifdef PRIM_ARB_MUX_LOCK_EN
        .i_last  (last),
`endif
        .o_ready (ready_fp),
        .o_valid (valid_fp),
        .o_data  (data_fp),
        .o_sel   (sel_fp),
`ifdef PRIM_ARB_MUX_LOCK_EN
        .o_last  (last_fp),
`endif
        .i_ready (rdy)
    );

    typedef struct {
        logic [N-1:0] v;
        logic         r;
        logic [N-1:0] lst;
        logic [N-1:0] er;
    } vec_t;

    typedef struct {
        logic [W-1:0]  d;
        logic [SW-1:0] s;
        logic          l;
    } beat_t;

    vec_t        tbl[$];
    beat_t       sb[$];
    int          n_checks = 0;
    int          n_err    = 0;
    logic [31:0] base;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    task automatic set_base(input logic [31:0] b);
        base = b;
        for (int k = 0; k < N; k++) data[k*W +: W] = b + 32'(k);
    endtask

    task automatic check_out(input string nm);
        chk({nm, ".o_valid"}, 64'(cur_valid), 64'(sb.size() > 0));
        if (sb.size() > 0) begin
            chk({nm, ".o_data"}, 64'(cur_data), 64'(sb[0].d));
            chk({nm, ".o_sel"},  64'(cur_sel),  64'(sb[0].s));
`ifdef PRIM_ARB_MUX_LOCK_EN
            chk({nm, ".o_last"}, 64'(cur_last), 64'(sb[0].l));
`endif
        end
    endtask

    task automatic apply(input logic [N-1:0] v, input logic r, input logic [N-1:0] lst,
                         input logic [N-1:0] er, input string nm);
        @(negedge i_clk);
        rst_n = 1'b1;
        valid = v;
        rdy   = r;
`ifdef PRIM_ARB_MUX_LOCK_EN
        last  = lst;
`endif
        #1;
        chk({nm, ".o_ready"}, 64'(cur_ready), 64'(er));
        if (sb.size() > 0 && r) void'(sb.pop_front());
        for (int k = 0; k < N; k++) begin
            if (er[k]) sb.push_back('{base + 32'(k), SW'(k), lst[k]});
        end
        @(posedge i_clk);
        #1;
        check_out(nm);
    endtask

    task automatic do_reset(input int n, input string nm);
        for (int i = 0; i < n; i++) begin
            @(negedge i_clk);
            rst_n = 1'b0;
            valid = '1;
            rdy   = 1'b1;
            #1;
            chk({nm, ".rr_ready"}, 64'(ready_rr), 64'd0);
            chk({nm, ".fp_ready"}, 64'(ready_fp), 64'd0);
            @(posedge i_clk);
            #1;
            chk({nm, ".o_valid"}, 64'(cur_valid), 64'd0);
            chk({nm, ".o_data"},  64'(cur_data),  64'd0);
            chk({nm, ".o_sel"},   64'(cur_sel),   64'd0);
        end
        sb.delete();
    endtask

    task automatic add(input logic [N-1:0] v, input logic r, input logic [N-1:0] lst,
                       input logic [N-1:0] er);
        tbl.push_back('{v, r, lst, er});
    endtask

    task automatic run_tbl(input string pfx);
        foreach (tbl[i]) apply(tbl[i].v, tbl[i].r, tbl[i].lst, tbl[i].er,
                               $sformatf("%s[%0d]", pfx, i));
        tbl.delete();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached before end of test");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0;
        valid = '0;
        rdy   = 1'b0;
`ifdef PRIM_ARB_MUX_LOCK_EN
        last  = '1;
`endif
        use_rr = 1'b1;
        set_base(32'h100);
        do_reset(2, "rst");

        // Round-robin sweep, back-pressure, wrap with sparse requests, idle, single requester.
        for (int i = 0; i < 9; i++) add(8'hFF, 1'b1, 8'hFF, 8'(1 << (i % 8)));
        for (int i = 0; i < 3; i++) add(8'hFF, 1'b0, 8'hFF, 8'h00);
        add(8'hFF, 1'b1, 8'hFF, 8'h02);
        add(8'hFF, 1'b1, 8'hFF, 8'h04);
        add(8'hFF, 1'b1, 8'hFF, 8'h08);
        add(8'hFF, 1'b1, 8'hFF, 8'h10);
        add(8'hFF, 1'b1, 8'hFF, 8'h20);
        add(8'h42, 1'b1, 8'hFF, 8'h40);
        add(8'h42, 1'b1, 8'hFF, 8'h02);
        add(8'h42, 1'b1, 8'hFF, 8'h40);
        add(8'h00, 1'b1, 8'hFF, 8'h00);
        add(8'h00, 1'b1, 8'hFF, 8'h00);
        for (int i = 0; i < 3; i++) add(8'h10, 1'b1, 8'hFF, 8'h10);
        run_tbl("rr");

        // Reset while a beat sits in the output register; pointer must restart at 0.
        do_reset(1, "rst_mid");
        apply(8'hFF, 1'b1, 8'hFF, 8'h01, "post_rst");
        apply(8'hFF, 1'b1, 8'hFF, 8'h02, "post_rst2");

        use_rr = 1'b0;
        set_base(32'h200);
        do_reset(2, "rst_fp");
        add(8'hFF, 1'b1, 8'hFF, 8'h01);
        add(8'hFF, 1'b1, 8'hFF, 8'h01);
        for (int i = 0; i < 3; i++) add(8'hA4, 1'b1, 8'hFF, 8'h04);
        add(8'hA0, 1'b1, 8'hFF, 8'h20);
        add(8'hA0, 1'b1, 8'hFF, 8'h20);
        add(8'h80, 1'b1, 8'hFF, 8'h80);
        add(8'hA4, 1'b0, 8'hFF, 8'h00);
        add(8'hA4, 1'b0, 8'hFF, 8'h00);
        add(8'hA4, 1'b1, 8'hFF, 8'h04);
        add(8'h00, 1'b1, 8'hFF, 8'h00);
        run_tbl("fp");

`ifdef PRIM_ARB_MUX_LOCK_EN
        use_rr = 1'b1;
        set_base(32'h300);
        do_reset(1, "rst_lk");
        add(8'h08, 1'b1, 8'h01, 8'h08);
        add(8'h09, 1'b1, 8'h01, 8'h08);
        add(8'h09, 1'b1, 8'h01, 8'h08);
        add(8'h09, 1'b1, 8'h09, 8'h08);
        add(8'h09, 1'b1, 8'h09, 8'h01);
        add(8'h09, 1'b1, 8'h09, 8'h08);
        run_tbl("lock");
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
